// File: rtl/proc_sequencer_pkg.sv
// Shared types for the downsampling-processor sequencer: state encoding,
// error cause codes and a small helper used by the FSM.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAM_RD  = 3'd1,
        ST_PROC_RUN = 3'd2,
        ST_DRAM_WR  = 3'd3,
        ST_COMPLETE = 3'd4,
        ST_ERROR    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RD_TO   = 2'd1;
    localparam logic [1:0] ERR_PROC_TO = 2'd2;
    localparam logic [1:0] ERR_WR_TO   = 2'd3;

    // True in the three phases that wait on an external done pulse.
    function automatic logic isActive(input state_e s);
        return (s == ST_DRAM_RD) || (s == ST_PROC_RUN) || (s == ST_DRAM_WR);
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Control bundle between the host / DRAM controllers / processor core and the
// sequencer. master drives the requests and done pulses, slave is the sequencer.
interface proc_seq_if #(
    parameter int TILE_W = 8
);
    logic              start;
    logic              abort;
    logic              rd_done;
    logic              finish;
    logic              wr_done;
    logic              rd_en;
    logic              enable;
    logic              wr_en;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [2:0]        state_o;

    modport master (
        output start, abort, rd_done, finish, wr_done,
        input  rd_en, enable, wr_en, tile_idx, busy, done, error, err_code, state_o
    );

    modport slave (
        input  start, abort, rd_done, finish, wr_done,
        output rd_en, enable, wr_en, tile_idx, busy, done, error, err_code, state_o
    );
endinterface

// File: rtl/proc_sequencer_watchdog.sv
// Per-phase watchdog: counts cycles spent in the current phase and flags the
// last allowed cycle. TIMEOUT_CYCLES == 0 pins the counter and never expires.
module phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam logic [TO_W-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear || (TIMEOUT_CYCLES == 0)) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    // Expiry marks the final permitted cycle; the FSM decides whether it is fatal.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/proc_sequencer.sv
// Top-level tile sequencer: DRAM read -> process -> DRAM write for each tile,
// with start/abort control, per-phase watchdog and a sticky error state.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int NUM_TILES      = 4,
    parameter int TILE_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    proc_seq_if.slave   io_seq
);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

    state_e            r_state;
    state_e            w_nextState;
    logic [TILE_W-1:0] r_tileIdx;
    logic [TILE_W-1:0] w_nextTile;
    logic [1:0]        r_errCode;
    logic [1:0]        w_nextErr;
    logic              w_expired;
    logic              w_wdClear;

    assign w_wdClear = (w_nextState != r_state);

    phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wdClear),
        .i_enable  (isActive(r_state)),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tileIdx <= '0;
            r_errCode <= ERR_NONE;
        end else begin
            r_state   <= w_nextState;
            r_tileIdx <= w_nextTile;
            r_errCode <= w_nextErr;
        end
    end

    // In each active phase: abort beats the phase's done input, which beats timeout.
    always_comb begin
        w_nextState = r_state;
        w_nextTile  = r_tileIdx;
        w_nextErr   = r_errCode;
        case (r_state)
            ST_IDLE, ST_COMPLETE: begin
                if (io_seq.start) begin
                    w_nextState = ST_DRAM_RD;
                    w_nextTile  = '0;
                    w_nextErr   = ERR_NONE;
                end
            end
            ST_DRAM_RD: begin
                if (io_seq.abort) begin
                    w_nextState = ST_IDLE;
                    w_nextTile  = '0;
                end else if (io_seq.rd_done) begin
                    w_nextState = ST_PROC_RUN;
                end else if (w_expired) begin
                    w_nextState = ST_ERROR;
                    w_nextErr   = ERR_RD_TO;
                end
            end
            ST_PROC_RUN: begin
                if (io_seq.abort) begin
                    w_nextState = ST_IDLE;
                    w_nextTile  = '0;
                end else if (io_seq.finish) begin
                    w_nextState = ST_DRAM_WR;
                end else if (w_expired) begin
                    w_nextState = ST_ERROR;
                    w_nextErr   = ERR_PROC_TO;
                end
            end
            ST_DRAM_WR: begin
                if (io_seq.abort) begin
                    w_nextState = ST_IDLE;
                    w_nextTile  = '0;
                end else if (io_seq.wr_done) begin
                    if (r_tileIdx == LAST_TILE) begin
                        w_nextState = ST_COMPLETE;
                    end else begin
                        w_nextState = ST_DRAM_RD;
                        w_nextTile  = r_tileIdx + TILE_W'(1);
                    end
                end else if (w_expired) begin
                    w_nextState = ST_ERROR;
                    w_nextErr   = ERR_WR_TO;
                end
            end
            ST_ERROR: begin
                w_nextState = ST_ERROR;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign io_seq.rd_en    = (r_state == ST_DRAM_RD);
    assign io_seq.enable   = (r_state == ST_PROC_RUN);
    assign io_seq.wr_en    = (r_state == ST_DRAM_WR);
    assign io_seq.busy     = isActive(r_state);
    assign io_seq.done     = (r_state == ST_COMPLETE);
    assign io_seq.error    = (r_state == ST_ERROR);
    assign io_seq.tile_idx = r_tileIdx;
    assign io_seq.err_code = r_errCode;
    assign io_seq.state_o  = r_state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: stimulus queues each expected output
// change, and a negedge monitor checks every change it sees against the queue.
module tb_proc_sequencer;
    import proc_seq_pkg::*;

    localparam int NUM_TILES      = 2;
    localparam int TILE_W         = 8;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int TO_W           = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    proc_seq_if #(.TILE_W(TILE_W)) io ();

    proc_sequencer #(
        .NUM_TILES      (NUM_TILES),
        .TILE_W         (TILE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_seq (io)
    );

    typedef struct {
        logic [2:0]        st;
        logic [TILE_W-1:0] tile;
        logic [1:0]        err;
        int                dwell;
    } exp_t;

    typedef struct packed {
        logic [2:0]        st;
        logic [TILE_W-1:0] tile;
        logic [1:0]        err;
        logic [5:0]        flags;
    } snap_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    bit   monitorOn = 1'b0;

    // Reference decode of {rd_en, enable, wr_en, busy, done, error} for a state.
    function automatic logic [5:0] flagsFor(input logic [2:0] st);
        return {st == 3'd1, st == 3'd2, st == 3'd3,
                (st >= 3'd1) && (st <= 3'd3), st == 3'd4, st == 3'd5};
    endfunction

    function automatic snap_t takeSnap();
        snap_t s;
        s.st    = io.state_o;
        s.tile  = io.tile_idx;
        s.err   = io.err_code;
        s.flags = {io.rd_en, io.enable, io.wr_en, io.busy, io.done, io.error};
        return s;
    endfunction

    initial begin
        snap_t prev;
        snap_t cur;
        exp_t  e;
        int    dwell;
        bit    ok;
        wait (monitorOn);
        @(negedge clk);
        prev  = takeSnap();
        dwell = 1;
        while (monitorOn) begin
            @(negedge clk);
            cur = takeSnap();
            if (cur != prev) begin
                testsRun++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpectedEvent: got state=%0d tile=%0d err=%0d flags=%b, required no change from state=%0d",
                             cur.st, cur.tile, cur.err, cur.flags, prev.st);
                end else begin
                    e  = expQ.pop_front();
                    ok = (cur.st == e.st) && (cur.tile == e.tile) && (cur.err == e.err) &&
                         (cur.flags == flagsFor(e.st)) && ((e.dwell < 0) || (dwell == e.dwell));
                    if (!ok) begin
                        failCount++;
                        $display("[TB] FAIL event: got state=%0d tile=%0d err=%0d flags=%b after %0d cycles, required state=%0d tile=%0d err=%0d flags=%b after %0d cycles",
                                 cur.st, cur.tile, cur.err, cur.flags, dwell,
                                 e.st, e.tile, e.err, flagsFor(e.st), e.dwell);
                    end
                end
                dwell = 1;
            end else begin
                dwell++;
            end
            prev = cur;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic rd,
                                 input logic fin, input logic wr);
        io.start   = st;
        io.abort   = ab;
        io.rd_done = rd;
        io.finish  = fin;
        io.wr_done = wr;
        tick();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic expectEvent(input state_e st, input int tile, input logic [1:0] err,
                               input int dwell);
        exp_t e;
        e.st    = st;
        e.tile  = TILE_W'(tile);
        e.err   = err;
        e.dwell = dwell;
        expQ.push_back(e);
    endtask

    // which: 0 = rd_done, 1 = finish, 2 = wr_done; pulsed after 'delay' idle cycles.
    task automatic servePhase(input int delay, input int which);
        repeat (delay) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, which == 0, which == 1, which == 2);
    endtask

    task automatic startRun();
        expectEvent(ST_DRAM_RD, 0, ERR_NONE, -1);
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic runTile(input int tile, input bit last);
        expectEvent(ST_PROC_RUN, tile, ERR_NONE, 4);
        servePhase(3, 0);
        expectEvent(ST_DRAM_WR, tile, ERR_NONE, 4);
        servePhase(3, 1);
        if (last) expectEvent(ST_COMPLETE, tile, ERR_NONE, 4);
        else      expectEvent(ST_DRAM_RD, tile + 1, ERR_NONE, 4);
        servePhase(3, 2);
    endtask

    initial begin
        io.start = 0; io.abort = 0; io.rd_done = 0; io.finish = 0; io.wr_done = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("resetState", int'(io.state_o), 0);
        checkOutput("resetFlags", int'({io.rd_en, io.enable, io.wr_en, io.busy, io.done, io.error}), 0);
        checkOutput("resetTile", int'(io.tile_idx), 0);
        checkOutput("resetErr", int'(io.err_code), 0);
        monitorOn = 1'b1;
        applyStimulus(0, 1, 0, 0, 0);

        // Full two-tile run
        startRun();
        checkOutput("startLatency", int'(io.rd_en), 1);
        runTile(0, 0);
        runTile(1, 1);
        checkOutput("completeDone", int'(io.done), 1);
        checkOutput("completeBusy", int'(io.busy), 0);
        checkOutput("completeTile", int'(io.tile_idx), 1);

        // Restart from COMPLETE, held rd_done, abort in PROC_RUN of tile 1
        startRun();
        checkOutput("restartTile", int'(io.tile_idx), 0);
        expectEvent(ST_PROC_RUN, 0, ERR_NONE, 1);
        repeat (5) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("heldRdDone", int'(io.state_o), 2);
        expectEvent(ST_DRAM_WR, 0, ERR_NONE, -1);
        servePhase(1, 1);
        expectEvent(ST_DRAM_RD, 1, ERR_NONE, 4);
        servePhase(3, 2);
        expectEvent(ST_PROC_RUN, 1, ERR_NONE, 4);
        servePhase(3, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        expectEvent(ST_IDLE, 0, ERR_NONE, 3);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("abortEnable", int'(io.enable), 0);
        checkOutput("abortTile", int'(io.tile_idx), 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("strayWrDone", int'(io.state_o), 0);
        startRun();
        runTile(0, 0);
        runTile(1, 1);

        // Finish coincident with expiry, then start and reset during DRAM_WR
        startRun();
        expectEvent(ST_PROC_RUN, 0, ERR_NONE, 4);
        servePhase(3, 0);
        expectEvent(ST_DRAM_WR, 0, ERR_NONE, 8);
        servePhase(7, 1);
        checkOutput("coincidentNoError", int'(io.error), 0);
        expectEvent(ST_DRAM_RD, 1, ERR_NONE, 4);
        servePhase(3, 2);
        expectEvent(ST_PROC_RUN, 1, ERR_NONE, 4);
        servePhase(3, 0);
        expectEvent(ST_DRAM_WR, 1, ERR_NONE, 4);
        servePhase(3, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("startWhileBusy", int'(io.state_o), 3);
        expectEvent(ST_IDLE, 0, ERR_NONE, -1);
        pulseReset();
        checkOutput("midResetFlags", int'({io.rd_en, io.enable, io.wr_en, io.busy, io.done, io.error}), 0);
        checkOutput("midResetState", int'(io.state_o), 0);

        // Read timeout, then ERROR ignores start and abort
        startRun();
        expectEvent(ST_ERROR, 0, ERR_RD_TO, 8);
        repeat (12) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rdTimeoutErr", int'(io.err_code), 1);
        checkOutput("rdTimeoutEnables", int'({io.rd_en, io.enable, io.wr_en}), 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("errorSticky", int'(io.state_o), 5);
        expectEvent(ST_IDLE, 0, ERR_NONE, -1);
        pulseReset();

        // Processing timeout
        startRun();
        expectEvent(ST_PROC_RUN, 0, ERR_NONE, 1);
        servePhase(0, 0);
        expectEvent(ST_ERROR, 0, ERR_PROC_TO, 8);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);
        expectEvent(ST_IDLE, 0, ERR_NONE, -1);
        pulseReset();

        // Write timeout
        startRun();
        expectEvent(ST_PROC_RUN, 0, ERR_NONE, 1);
        servePhase(0, 0);
        expectEvent(ST_DRAM_WR, 0, ERR_NONE, 1);
        servePhase(0, 1);
        expectEvent(ST_ERROR, 0, ERR_WR_TO, 8);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrTimeoutErr", int'(io.err_code), 3);

        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        monitorOn = 1'b0;
        checkOutput("scoreboardDrained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
